sr_pq_param: RTL and testbench
==============================

Name: sr_pq_param

Overview:
- Parametrised shift-register (sorted register array) priority queue; next generation of the fixed-width heap_pq top level.
- Configurable key and value widths, depth, and min-first or max-first ordering.
- Single-cycle enqueue, dequeue and simultaneous replace (enq+deq).
- FIFO ordering among equal keys, occupancy count, sticky overflow/underflow flags, synchronous flush.
- Flat pins; drops directly into the PQ wrapper/synthesis top level.

Parameters:
- KEY_W, 8, key width in bits; keys compare as unsigned.
- VAL_W, 8, value (payload) width in bits.
- DEPTH, 16, number of entries; legal range 2..64.
- MODE, PQ_MIN, ordering. PQ_MIN dequeues the smallest key first; PQ_MAX dequeues the largest key first.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, synchronous active-low reset; takes effect on the rising clk edge while low.
- enq, in, 1, enqueue request; kvi_key/kvi_val are sampled this cycle.
- kvi_key, in, KEY_W, key to insert.
- kvi_val, in, VAL_W, value to insert.
- deq, in, 1, dequeue request; pops the current head.
- flush, in, 1, synchronous clear of contents and flags.
- kvo_key, out, KEY_W, head key (registered); valid when !empty.
- kvo_val, out, VAL_W, head value (registered).
- empty, out, 1, count==0.
- full, out, 1, count==DEPTH.
- busy, out, 1, constant 0; every operation completes in one cycle. Kept for pq_if compatibility.
- count, out, $clog2(DEPTH+1), number of occupied entries.
- ovf, out, 1, sticky: an enqueue was dropped.
- udf, out, 1, sticky: a dequeue was ignored.

Behaviour:
- Storage: DEPTH slots, each {valid, key, val}. Slot 0 is the head. Valid slots are contiguous from slot 0, sorted by MODE.
- Reset (rst==0): all valid=0, slot data=0, count=0, ovf=0, udf=0. Outputs: kvo_key/kvo_val=0, empty=1, full=0, busy=0. Reset has priority over every input, including mid-operation.
- Priority below reset: flush, then enq/deq. A flush clears slots, count, ovf and udf as reset does; enq/deq in the same cycle are ignored.
- Enqueue only (enq & !deq & !full):
  - Insert at the first slot i whose key is strictly worse than kvi_key (MIN: key > kvi_key; MAX: key < kvi_key), or at slot count if there is none.
  - Slots i..count-1 shift toward the tail by one; count+1.
  - Equal keys land after existing equals (stable, insertion order).
- Dequeue only (deq & !enq & !empty): slots shift toward the head by one; the tail slot is invalidated; count-1.
- Replace (enq & deq & !empty): the head is removed and kvi is inserted into the remaining count-1 entries by the same stable rule; count unchanged. Legal when full.
- Enq when full without deq: dropped; ovf<=1; contents unchanged.
- Deq when empty: ignored; udf<=1. If enq is also asserted, the enqueue still proceeds (count becomes 1).
- Latency:
  - Head outputs reflect the op on the next cycle. Example: enq at edge N makes kvo visible after edge N.
  - empty, full and count are derived from the registered count.
- kvo_key/kvo_val equal slot 0 contents and are 0 while empty.
- Comparator/shift control is per slot: each slot compares kvi against itself and its predecessor. No FSM; critical path is one compare plus a 3:1 mux.

Decomposition:
- pq_pkg gains:
  - typedef enum pq_mode_t {PQ_MIN, PQ_MAX};
  - default constants PQ_KEY_W and PQ_VAL_W;
  - function pq_better(a, b, mode), a strict-priority compare.
- Sub-module sr_pq_cell, one per slot:
  - inputs: own and neighbour {valid, key, val}, kvi, and op controls;
  - output: next-state slot contents.
- sr_pq_param owns count, flags and the generate loop of cells.

Test Plan:
- Reset: hold rst=0 for 2 cycles with enq=1 -> empty=1, count=0, kvo_key=0, ovf=udf=0.
- Ordering (MIN, DEPTH=4): enq keys 30, 10, 20 -> kvo_key=10, count=3; three deqs return 10, 20, 30; then empty=1.
- Ties: enq (5,0xA), (5,0xB), (5,0xC) -> deqs return vals 0xA, 0xB, 0xC in order.
- Full/replace (DEPTH=4):
  - Fill with 4, 6, 8, 9; enq 2 alone -> dropped, ovf=1, count=4, head=4.
  - Then enq+deq with key 7 -> head=6, contents 6, 7, 8, 9, count=4.
- Empty/flush:
  - deq on empty -> udf=1, count=0.
  - enq+deq with key 3 on empty -> count=1, head=3.
  - flush -> count=0, udf=0, ovf=0.
- MODE=PQ_MAX:
  - enq 3, 9, 7 -> deqs return 9, 7, 3.
  - rst=0 pulsed between the 1st and 2nd deq -> next cycle empty=1, count=0, kvo_key=0.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared types, defaults and the key-priority compare for the priority queue family.
package pq_pkg;

    localparam int PQ_KEY_W = 8;
    localparam int PQ_VAL_W = 8;

    typedef enum logic {PQ_MIN, PQ_MAX} pq_mode_t;

    // Per-cycle operation broadcast to every slot cell.
    typedef enum logic [1:0] {OP_HOLD, OP_ENQ, OP_DEQ, OP_REP} pq_op_t;

    // True when key a must leave the queue strictly before key b.
    function automatic logic pq_better(input logic [63:0] a, input logic [63:0] b,
                                       input pq_mode_t mode);
        return (mode == PQ_MIN) ? (a < b) : (a > b);
    endfunction

endpackage

// File: rtl/sr_pq_cell.sv
// One slot of the sorted register array: computes its own next contents from itself,
// its neighbours and the incoming key/value.
module sr_pq_cell
    import pq_pkg::*;
#(
    parameter int       KEY_W = PQ_KEY_W,
    parameter int       VAL_W = PQ_VAL_W,
    parameter pq_mode_t MODE  = PQ_MIN
) (
    input  pq_op_t           op,
    input  logic             head,
    input  logic [KEY_W-1:0] kvi_key,
    input  logic [VAL_W-1:0] kvi_val,
    input  logic             own_valid,
    input  logic [KEY_W-1:0] own_key,
    input  logic [VAL_W-1:0] own_val,
    input  logic             prev_valid,
    input  logic [KEY_W-1:0] prev_key,
    input  logic [VAL_W-1:0] prev_val,
    input  logic             next_valid,
    input  logic [KEY_W-1:0] next_key,
    input  logic [VAL_W-1:0] next_val,
    input  logic             keep_prev,
    input  logic             keep_next,
    output logic             keep,
    output logic             valid_d,
    output logic [KEY_W-1:0] key_d,
    output logic [VAL_W-1:0] val_d
);

    // A slot keeps its place when it holds a key at least as good as kvi;
    // equal keys stay ahead, which gives FIFO order among ties.
    assign keep = own_valid & ~pq_better(64'(kvi_key), 64'(own_key), MODE);

    always_comb begin
        valid_d = own_valid;
        key_d   = own_key;
        val_d   = own_val;
        case (op)
            OP_ENQ: begin
                if (!keep) begin
                    if (keep_prev) begin
                        valid_d = 1'b1;
                        key_d   = kvi_key;
                        val_d   = kvi_val;
                    end else begin
                        valid_d = prev_valid;
                        key_d   = prev_key;
                        val_d   = prev_val;
                    end
                end
            end
            OP_DEQ: begin
                valid_d = next_valid;
                key_d   = next_key;
                val_d   = next_val;
            end
            OP_REP: begin
                // Head is removed: the array shifts headward up to the insert point.
                if (keep_next) begin
                    valid_d = next_valid;
                    key_d   = next_key;
                    val_d   = next_val;
                end else if (head || keep) begin
                    valid_d = 1'b1;
                    key_d   = kvi_key;
                    val_d   = kvi_val;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sr_pq_param.sv
// Parametrised shift-register priority queue: single-cycle enqueue, dequeue and replace,
// stable among equal keys, with occupancy count and sticky overflow/underflow flags.
module sr_pq_param
    import pq_pkg::*;
#(
    parameter int       KEY_W = PQ_KEY_W,
    parameter int       VAL_W = PQ_VAL_W,
    parameter int       DEPTH = 16,
    parameter pq_mode_t MODE  = PQ_MIN,
    localparam int      CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic [KEY_W-1:0] kvi_key,
    input  logic [VAL_W-1:0] kvi_val,
    input  logic             deq,
    input  logic             flush,
    output logic [KEY_W-1:0] kvo_key,
    output logic [VAL_W-1:0] kvo_val,
    output logic             empty,
    output logic             full,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic             udf
);

    logic             valid_q [DEPTH];
    logic [KEY_W-1:0] key_q   [DEPTH];
    logic [VAL_W-1:0] val_q   [DEPTH];
    logic             valid_d [DEPTH];
    logic [KEY_W-1:0] key_d   [DEPTH];
    logic [VAL_W-1:0] val_d   [DEPTH];

    logic             cell_valid [DEPTH];
    logic [KEY_W-1:0] cell_key   [DEPTH];
    logic [VAL_W-1:0] cell_val   [DEPTH];
    logic             keep_w     [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    pq_op_t           op;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign busy    = 1'b0;
    assign count   = count_q;
    assign ovf     = ovf_q;
    assign udf     = udf_q;
    assign kvo_key = empty ? '0 : key_q[0];
    assign kvo_val = empty ? '0 : val_q[0];

    // A dequeue on an empty queue with enq set degrades to a plain enqueue.
    always_comb begin
        op      = OP_HOLD;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush) begin
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (enq && deq && !empty) begin
                op = OP_REP;
            end else if (enq && (!deq || empty) && !full) begin
                op      = OP_ENQ;
                count_d = count_q + CNT_W'(1);
            end else if (deq && !enq && !empty) begin
                op      = OP_DEQ;
                count_d = count_q - CNT_W'(1);
            end
            if (enq && !deq && full) ovf_d = 1'b1;
            if (deq && empty)        udf_d = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic             pv, nv, kp, kn;
            logic [KEY_W-1:0] pk, nk;
            logic [VAL_W-1:0] pval, nval;

            if (gi == 0) begin : g_head
                assign pv   = 1'b0;
                assign pk   = '0;
                assign pval = '0;
                assign kp   = 1'b1;
            end else begin : g_mid
                assign pv   = valid_q[gi-1];
                assign pk   = key_q[gi-1];
                assign pval = val_q[gi-1];
                assign kp   = keep_w[gi-1];
            end

            if (gi == DEPTH - 1) begin : g_tail
                assign nv   = 1'b0;
                assign nk   = '0;
                assign nval = '0;
                assign kn   = 1'b0;
            end else begin : g_body
                assign nv   = valid_q[gi+1];
                assign nk   = key_q[gi+1];
                assign nval = val_q[gi+1];
                assign kn   = keep_w[gi+1];
            end

            sr_pq_cell #(
                .KEY_W (KEY_W),
                .VAL_W (VAL_W),
                .MODE  (MODE)
            ) u_cell (
                .op         (op),
                .head       (gi == 0),
                .kvi_key    (kvi_key),
                .kvi_val    (kvi_val),
                .own_valid  (valid_q[gi]),
                .own_key    (key_q[gi]),
                .own_val    (val_q[gi]),
                .prev_valid (pv),
                .prev_key   (pk),
                .prev_val   (pval),
                .next_valid (nv),
                .next_key   (nk),
                .next_val   (nval),
                .keep_prev  (kp),
                .keep_next  (kn),
                .keep       (keep_w[gi]),
                .valid_d    (cell_valid[gi]),
                .key_d      (cell_key[gi]),
                .val_d      (cell_val[gi])
            );

            assign valid_d[gi] = flush ? 1'b0 : cell_valid[gi];
            assign key_d[gi]   = flush ? '0   : cell_key[gi];
            assign val_d[gi]   = flush ? '0   : cell_val[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                key_q[i]   <= '0;
                val_q[i]   <= '0;
            end
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= valid_d[i];
                key_q[i]   <= key_d[i];
                val_q[i]   <= val_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sr_pq_param.sv
// Directed bench for sr_pq_param: a min-first and a max-first queue, DEPTH=4, shared stimulus.
module tb_sr_pq_param;
    import pq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enq = 1'b0;
    logic       deq = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] kvi_key = '0;
    logic [7:0] kvi_val = '0;

    logic [7:0] mn_key, mn_val, mx_key, mx_val;
    logic       mn_empty, mn_full, mn_busy, mn_ovf, mn_udf;
    logic       mx_empty, mx_full, mx_busy, mx_ovf, mx_udf;
    logic [2:0] mn_count, mx_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sr_pq_param #(.KEY_W(8), .VAL_W(8), .DEPTH(4), .MODE(PQ_MIN)) u_min (
        .clk(clk), .rst(rst), .enq(enq), .kvi_key(kvi_key), .kvi_val(kvi_val),
        .deq(deq), .flush(flush), .kvo_key(mn_key), .kvo_val(mn_val),
        .empty(mn_empty), .full(mn_full), .busy(mn_busy), .count(mn_count),
        .ovf(mn_ovf), .udf(mn_udf)
    );

    sr_pq_param #(.KEY_W(8), .VAL_W(8), .DEPTH(4), .MODE(PQ_MAX)) u_max (
        .clk(clk), .rst(rst), .enq(enq), .kvi_key(kvi_key), .kvi_val(kvi_val),
        .deq(deq), .flush(flush), .kvo_key(mx_key), .kvo_val(mx_val),
        .empty(mx_empty), .full(mx_full), .busy(mx_busy), .count(mx_count),
        .ovf(mx_ovf), .udf(mx_udf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One clock of stimulus; outputs are settled and sampled 1 time unit after the edge.
    task automatic step(input logic e, input logic d, input logic f,
                        input logic [7:0] k, input logic [7:0] v);
        enq = e; deq = d; flush = f; kvi_key = k; kvi_val = v;
        @(posedge clk);
        #1;
        enq = 1'b0; deq = 1'b0; flush = 1'b0;
    endtask

    initial begin
        // Reset held two cycles while enq is requested.
        rst = 1'b0;
        step(1, 0, 0, 8'd5, 8'd1);
        step(1, 0, 0, 8'd5, 8'd1);
        check_eq("rst_empty", mn_empty, 1);
        check_eq("rst_count", mn_count, 0);
        check_eq("rst_key",   mn_key, 0);
        check_eq("rst_ovf",   mn_ovf, 0);
        check_eq("rst_udf",   mn_udf, 0);
        check_eq("rst_full",  mn_full, 0);
        check_eq("busy",      mn_busy, 0);
        rst = 1'b1;

        // Ordering, min-first.
        step(1, 0, 0, 8'd30, 8'd31);
        step(1, 0, 0, 8'd10, 8'd11);
        step(1, 0, 0, 8'd20, 8'd21);
        check_eq("ord_head",  mn_key, 10);
        check_eq("ord_hval",  mn_val, 11);
        check_eq("ord_count", mn_count, 3);
        step(0, 1, 0, 8'd0, 8'd0);
        check_eq("ord_deq1",  mn_key, 20);
        step(0, 1, 0, 8'd0, 8'd0);
        check_eq("ord_deq2",  mn_key, 30);
        check_eq("ord_dval2", mn_val, 31);
        step(0, 1, 0, 8'd0, 8'd0);
        check_eq("ord_empty", mn_empty, 1);
        check_eq("ord_zkey",  mn_key, 0);

        // Equal keys leave in insertion order.
        step(1, 0, 0, 8'd5, 8'hA);
        step(1, 0, 0, 8'd5, 8'hB);
        step(1, 0, 0, 8'd5, 8'hC);
        check_eq("tie_v0", mn_val, 8'hA);
        step(0, 1, 0, 8'd0, 8'd0);
        check_eq("tie_v1", mn_val, 8'hB);
        step(0, 1, 0, 8'd0, 8'd0);
        check_eq("tie_v2", mn_val, 8'hC);
        step(0, 1, 0, 8'd0, 8'd0);
        check_eq("tie_empty", mn_empty, 1);

        // Full, dropped enqueue, then replace.
        step(1, 0, 0, 8'd4, 8'd0);
        step(1, 0, 0, 8'd6, 8'd0);
        step(1, 0, 0, 8'd8, 8'd0);
        step(1, 0, 0, 8'd9, 8'd0);
        check_eq("fill_full", mn_full, 1);
        step(1, 0, 0, 8'd2, 8'd0);
        check_eq("drop_ovf",   mn_ovf, 1);
        check_eq("drop_count", mn_count, 4);
        check_eq("drop_head",  mn_key, 4);
        step(1, 1, 0, 8'd7, 8'd77);
        check_eq("rep_head",  mn_key, 6);
        check_eq("rep_count", mn_count, 4);
        step(0, 1, 0, 8'd0, 8'd0);
        check_eq("rep_s1",     mn_key, 7);
        check_eq("rep_s1_val", mn_val, 77);
        step(0, 1, 0, 8'd0, 8'd0);
        check_eq("rep_s2", mn_key, 8);
        step(0, 1, 0, 8'd0, 8'd0);
        check_eq("rep_s3", mn_key, 9);
        step(0, 1, 0, 8'd0, 8'd0);
        check_eq("rep_empty", mn_empty, 1);
        check_eq("ovf_sticky", mn_ovf, 1);

        // Empty-side boundaries and flush.
        step(0, 1, 0, 8'd0, 8'd0);
        check_eq("udf_set",   mn_udf, 1);
        check_eq("udf_count", mn_count, 0);
        step(1, 1, 0, 8'd3, 8'd0);
        check_eq("ed_count", mn_count, 1);
        check_eq("ed_head",  mn_key, 3);
        step(1, 0, 1, 8'd1, 8'd0);
        check_eq("fl_count", mn_count, 0);
        check_eq("fl_udf",   mn_udf, 0);
        check_eq("fl_ovf",   mn_ovf, 0);
        check_eq("fl_empty", mn_empty, 1);

        // Max-first ordering, reset pulsed mid-drain.
        step(1, 0, 0, 8'd3, 8'd0);
        step(1, 0, 0, 8'd9, 8'd0);
        step(1, 0, 0, 8'd7, 8'd0);
        check_eq("max_head",  mx_key, 9);
        check_eq("min_head",  mn_key, 3);
        step(0, 1, 0, 8'd0, 8'd0);
        check_eq("max_deq1",  mx_key, 7);
        rst = 1'b0;
        step(0, 1, 0, 8'd0, 8'd0);
        rst = 1'b1;
        check_eq("max_rst_empty", mx_empty, 1);
        check_eq("max_rst_count", mx_count, 0);
        check_eq("max_rst_key",   mx_key, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
